cache_trace_player: RTL and testbench

Synthesizable replay engine that drives a stored 32-bit instruction trace into the cache (`main`) one instruction per clock, samples its `hit` response, and keeps hit/miss totals. It is the stimulus-and-scoreboard counterpart of the cache's instruction/hit interface, usable on silicon or in simulation without file I/O. It sits between a loader (CPU or debug port) and the cache under measurement.

---
 rtl/cache_trace_pkg.sv | 9 +
 rtl/trace_ram.sv | 21 ++
 rtl/cache_trace_player.sv | 129 ++++++++++++
 tb/tb_cache_trace_player.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cache_trace_pkg.sv
// Shared types and defaults for the cache trace replay engine.
package cache_trace_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam int IW_DEF      = 32;
   localparam int CW_DEF      = 32;
   localparam int HIT_LAT_MIN = 1;
   localparam int HIT_LAT_MAX = 4;
endpackage

// File: rtl/trace_ram.sv
// Trace buffer: one write port, one registered read port, contents never reset.
module trace_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int IW    = 32
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [IW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [IW-1:0] o_rdata
);
   logic [IW-1:0] r_mem [DEPTH];

   // Read returns the pre-write contents when addresses collide.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/cache_trace_player.sv
// Replays a stored instruction trace into the cache one beat per clock and
// scores the returned hit flag into saturating hit/miss counters.
module cache_trace_player
   import cache_trace_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int AW      = 8,
   parameter int IW      = IW_DEF,
   parameter int CW      = CW_DEF,
   parameter int HIT_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [IW-1:0] load_data,
   input  logic          start,
   input  logic [AW:0]   length,
   output logic [IW-1:0] instruction,
   output logic          instr_valid,
   input  logic          hit,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] hit_count,
   output logic [CW-1:0] miss_count
);
   if (HIT_LAT < HIT_LAT_MIN || HIT_LAT > HIT_LAT_MAX) begin : g_bad_lat
      $error("HIT_LAT out of range");
   end

   state_t          r_state, w_state_nxt;
   logic [AW:0]     r_len;
   logic [AW-1:0]   r_idx;
   logic [HIT_LAT-1:0] r_vld_pipe;
   logic [IW-1:0]   r_instr;
   logic            r_done;
   logic [CW-1:0]   r_hit, r_miss;

   logic            w_idle;
   logic            w_start_ok;
   logic            w_we;
   logic            w_last_beat;
   logic            w_pend;
   logic            w_tag;
   logic [AW:0]     w_len_clamp;
   logic [AW-1:0]   w_rd_addr;
   logic [IW-1:0]   w_rdata;

   assign w_idle      = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_start_ok  = start && w_idle;
   assign w_we        = load_en && w_idle;
   assign w_len_clamp = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
   assign w_last_beat = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
   assign w_tag       = r_vld_pipe[HIT_LAT-1];
   // Prefetch: address 0 is read while idle so beat 0 lands on the first RUN edge.
   assign w_rd_addr   = (r_state == ST_RUN) ? r_idx + AW'(1) : '0;

   // Beats still in flight ahead of the oldest pipeline stage.
   always_comb begin
      w_pend = 1'b0;
      for (int j = 0; j < HIT_LAT-1; j++) w_pend = w_pend | r_vld_pipe[j];
   end

   trace_ram #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (load_addr),
      .i_wdata (load_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_start_ok) w_state_nxt = (w_len_clamp == '0) ? ST_DONE : ST_RUN;
         ST_RUN:           if (w_last_beat) w_state_nxt = ST_DRAIN;
         ST_DRAIN:         if (!w_pend) w_state_nxt = ST_DONE;
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         r_idx      <= '0;
         r_vld_pipe <= '0;
         r_instr    <= '0;
         r_done     <= 1'b0;
         r_hit      <= '0;
         r_miss     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_vld_pipe[0] <= (r_state == ST_RUN);
         for (int j = 1; j < HIT_LAT; j++) r_vld_pipe[j] <= r_vld_pipe[j-1];

         if (w_start_ok) begin
            r_len <= w_len_clamp;
            r_idx <= '0;
         end else if (r_state == ST_RUN) begin
            r_idx <= r_idx + AW'(1);
         end

         if (r_state == ST_RUN) r_instr <= w_rdata;

         if (w_start_ok)                  r_done <= 1'b0;
         else if (w_state_nxt == ST_DONE) r_done <= 1'b1;

         if (w_start_ok) begin
            r_hit  <= '0;
            r_miss <= '0;
         end else if (w_tag) begin
            if (hit) begin
               if (r_hit != '1) r_hit <= r_hit + CW'(1);
            end else begin
               if (r_miss != '1) r_miss <= r_miss + CW'(1);
            end
         end
      end
   end

   assign instruction = r_instr;
   assign instr_valid = r_vld_pipe[0];
   assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done        = r_done;
   assign hit_count   = r_hit;
   assign miss_count  = r_miss;
endmodule

// File: tb/tb_cache_trace_player.sv
// Directed bench: three player instances (HIT_LAT=1, HIT_LAT=3, CW=4) share a load bus.
module tb_cache_trace_player;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_en = 1'b0;
   logic [7:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic [8:0]  length = '0;
   int          sel = 0;
   logic        hitA = 1'b0, hitB = 1'b1;

   logic [31:0] instrA, instrB, instrC;
   logic        vA, vB, vC, busyA, busyB, busyC, doneA, doneB, doneC;
   logic [31:0] hcA, mcA, hcB, mcB;
   logic [3:0]  hcC, mcC;
   logic        stA, stB, stC;

   assign stA = start && (sel == 0);
   assign stB = start && (sel == 1);
   assign stC = start && (sel == 2);

   always #5 clk = ~clk;

   cache_trace_player #(.HIT_LAT(1)) dutA (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(stA), .length(length), .instruction(instrA), .instr_valid(vA), .hit(hitA),
      .busy(busyA), .done(doneA), .hit_count(hcA), .miss_count(mcA));
   cache_trace_player #(.HIT_LAT(3)) dutB (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(stB), .length(length), .instruction(instrB), .instr_valid(vB), .hit(hitB),
      .busy(busyB), .done(doneB), .hit_count(hcB), .miss_count(mcB));
   cache_trace_player #(.HIT_LAT(1), .CW(4)) dutC (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(stC), .length(length), .instruction(instrC), .instr_valid(vC), .hit(1'b1),
      .busy(busyC), .done(doneC), .hit_count(hcC), .miss_count(mcC));

   logic [31:0] c_instr, c_hit, c_miss;
   logic        c_valid, c_busy, c_done;
   always_comb begin
      c_instr = instrA; c_valid = vA; c_busy = busyA; c_done = doneA; c_hit = hcA; c_miss = mcA;
      case (sel)
         1: begin c_instr = instrB; c_valid = vB; c_busy = busyB; c_done = doneB; c_hit = hcB; c_miss = mcB; end
         2: begin c_instr = instrC; c_valid = vC; c_busy = busyC; c_done = doneC;
                  c_hit = {28'd0, hcC}; c_miss = {28'd0, mcC}; end
         default: ;
      endcase
   end

   // Cache model for dutA: an address hits if it was presented earlier in the run.
   logic [31:0] seen[$];
   always @(negedge clk) begin
      if (vA) begin
         hitA = 1'b0;
         foreach (seen[j]) if (seen[j] == instrA) hitA = 1'b1;
         seen.push_back(instrA);
      end else begin
         hitA = 1'b0;
      end
   end

   int n_chk = 0, n_err = 0;
   logic [31:0] tr [256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int sel; int len; int pulse; int eh; int em; int lat;
   } vec_t;

   task automatic run(input vec_t v);
      int n, beat, nbeats;
      bit fin;
      beat = 0; fin = 0;
      nbeats = (v.len > 256) ? 256 : v.len;
      seen.delete();
      @(negedge clk);
      sel = v.sel; length = 9'(v.len); start = 1'b1; hitB = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_after_start", {31'd0, c_busy}, {31'd0, (v.len != 0)});
      chk("done_cleared", {31'd0, c_done}, 32'd0);
      for (n = 1; n <= 600; n++) begin
         @(negedge clk);
         if (v.pulse != 0 && n == v.pulse) begin
            start = 1'b1; length = 9'd2;
            load_en = 1'b1; load_addr = 8'd1; load_data = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; load_en = 1'b0;
         end
         hitB = !(n >= 4 && n <= v.len + 3);
         @(posedge clk);
         #1;
         if (c_valid) begin
            if (beat < 256) chk($sformatf("beat%0d", beat), c_instr, tr[beat]);
            beat++;
         end
         if (c_done) begin fin = 1; break; end
      end
      if (!fin) chk("done_timeout", 32'd0, 32'd1);
      chk("latency", 32'(n), 32'(v.lat));
      chk("beat_count", 32'(beat), 32'(nbeats));
      chk("hit_count", c_hit, 32'(v.eh));
      chk("miss_count", c_miss, 32'(v.em));
      chk("busy_at_done", {31'd0, c_busy}, 32'd0);
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{0, 4,   0, 2, 2,   5};
      tbl[1] = '{0, 0,   0, 0, 0,   1};
      tbl[2] = '{0, 1,   0, 0, 1,   2};
      tbl[3] = '{0, 16,  0, 2, 14,  17};
      tbl[4] = '{0, 3,   0, 1, 2,   4};
      tbl[5] = '{0, 300, 0, 2, 254, 257};
      tbl[6] = '{1, 8,   0, 0, 8,   11};
      tbl[7] = '{2, 20,  0, 15, 0,  21};
      tbl[8] = '{0, 4,   2, 2, 2,   5};
      tbl[9] = '{0, 4,   0, 2, 2,   5};
      for (int i = 0; i < 256; i++) tr[i] = (i < 4) ? ((i % 2 == 0) ? 32'h0 : 32'h4) : 32'(i * 4);

      #1;
      chk("rst_instr", instrA, 32'd0);
      chk("rst_valid", {31'd0, vA}, 32'd0);
      chk("rst_busy", {31'd0, busyA}, 32'd0);
      chk("rst_done", {31'd0, doneA}, 32'd0);
      chk("rst_counts", hcA | mcA, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         load_en = 1'b1; load_addr = 8'(i); load_data = tr[i];
      end
      @(negedge clk); load_en = 1'b0;

      foreach (tbl[i]) run(tbl[i]);

      // Asynchronous reset while beat 3 of 10 is on the bus.
      seen.delete();
      @(negedge clk); sel = 0; length = 9'd10; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_beat3", instrA, tr[3]);
      chk("pre_rst_valid", {31'd0, vA}, 32'd1);
      chk("pre_rst_hit", hcA, 32'd1);
      chk("pre_rst_miss", mcA, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_instr", instrA, 32'd0);
      chk("midrst_valid", {31'd0, vA}, 32'd0);
      chk("midrst_busy", {31'd0, busyA}, 32'd0);
      chk("midrst_done", {31'd0, doneA}, 32'd0);
      chk("midrst_hit", hcA, 32'd0);
      chk("midrst_miss", mcA, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run('{0, 2, 0, 0, 2, 3});

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
